// File: rtl/smpl_sweep.sv
// Sample sweep generator: walks the sample grid of one bounded triangle in raster order, one sample per cycle.
// Latency: the first sample appears 1 cycle after accept. Backpressure: halt_RnnnnL=0 freezes all state. Optional jitter: SAMPLE_JITTER_EN.
module smpl_sweep #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [SIGFIG-1:0] tri_R13S   [VERTS-1:0][AXIS-1:0],
  input  logic        [SIGFIG-1:0] color_R13U [COLORS-1:0],
  input  logic signed [SIGFIG-1:0] box_R13S   [1:0][1:0],
  input  logic                     validTri_R13H,
  output logic                     halt_R13L,
  input  logic        [3:0]        subSample_RnnnnU,
  input  logic                     halt_RnnnnL,
  output logic signed [SIGFIG-1:0] tri_R14S   [VERTS-1:0][AXIS-1:0],
  output logic        [SIGFIG-1:0] color_R14U [COLORS-1:0],
  output logic signed [SIGFIG-1:0] sample_R14S [1:0],
  output logic                     validSamp_R14H,
  output logic signed [SIGFIG-1:0] s_x_R14S,
  output logic signed [SIGFIG-1:0] s_y_R14S,
  output logic        [7:0]        jitter_x_R14S,
  output logic        [7:0]        jitter_y_R14S
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;

  logic [0:0]               state_q, state_d;
  logic                     halt13_q, halt13_d;
  logic                     vld_q, vld_d;
  logic signed [SIGFIG-1:0] sx_q, sx_d, sy_q, sy_d;
  logic signed [SIGFIG-1:0] llx_q, llx_d, urx_q, urx_d, ury_q, ury_d;
  logic        [SIGFIG-1:0] step_q, step_d;
  logic signed [SIGFIG-1:0] tri_q [VERTS-1:0][AXIS-1:0];
  logic signed [SIGFIG-1:0] tri_d [VERTS-1:0][AXIS-1:0];
  logic        [SIGFIG-1:0] col_q [COLORS-1:0];
  logic        [SIGFIG-1:0] col_d [COLORS-1:0];
  logic signed [SIGFIG-1:0] smpx_q, smpx_d, smpy_q, smpy_d;
  logic        [7:0]        jx_q, jx_d, jy_q, jy_d;

  logic                     load;
  logic        [1:0]        ss_lg2;
  logic        [SIGFIG-1:0] new_step;
  logic                     box_ok;
  logic signed [SIGFIG-1:0] smpx_n, smpy_n;
  logic        [7:0]        jx_n, jy_n;

  always_comb begin
    case (subSample_RnnnnU)
      4'b0001: ss_lg2 = 2'd3;
      4'b0010: ss_lg2 = 2'd2;
      4'b0100: ss_lg2 = 2'd1;
      default: ss_lg2 = 2'd0;
    endcase
    new_step = {{(SIGFIG-1){1'b0}}, 1'b1} << (RADIX - int'(ss_lg2));
    box_ok   = (box_R13S[0][0] <= box_R13S[1][0]) && (box_R13S[0][1] <= box_R13S[1][1]);
  end

  always_comb begin
    state_d  = state_q;
    halt13_d = halt13_q;
    vld_d    = vld_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    llx_d    = llx_q;
    urx_d    = urx_q;
    ury_d    = ury_q;
    step_d   = step_q;
    tri_d    = tri_q;
    col_d    = col_q;
    load     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (validTri_R13H && box_ok) begin
          state_d  = ST_SWEEP;
          halt13_d = 1'b0;
          vld_d    = 1'b1;
          sx_d     = box_R13S[0][0];
          sy_d     = box_R13S[0][1];
          llx_d    = box_R13S[0][0];
          urx_d    = box_R13S[1][0];
          ury_d    = box_R13S[1][1];
          step_d   = new_step;
          tri_d    = tri_R13S;
          col_d    = color_R13U;
          load     = 1'b1;
        end
      end
      default: begin
        if (halt_RnnnnL) begin
          if (sx_q == urx_q && sy_q == ury_q) begin
            state_d  = ST_IDLE;
            halt13_d = 1'b1;
            vld_d    = 1'b0;
          end else begin
            load = 1'b1;
            if (sx_q < urx_q) begin
              sx_d = sx_q + $signed(step_q);
            end else begin
              sx_d = llx_q;
              sy_d = sy_q + $signed(step_q);
            end
          end
        end
      end
    endcase
  end

  // Jitter follows the next grid point so it lands in the same register stage.
  always_comb begin
`ifdef SAMPLE_JITTER_EN
    jx_n   = {sx_d[RADIX+3:RADIX], sy_d[RADIX+3:RADIX]} ^ 8'hA5;
    jy_n   = {sy_d[RADIX+3:RADIX], sx_d[RADIX+3:RADIX]} ^ 8'h5A;
    smpx_n = sx_d + $signed((SIGFIG'(jx_n) * step_d) >> 8);
    smpy_n = sy_d + $signed((SIGFIG'(jy_n) * step_d) >> 8);
`else
    jx_n   = 8'h00;
    jy_n   = 8'h00;
    smpx_n = sx_d;
    smpy_n = sy_d;
`endif
    jx_d   = load ? jx_n   : jx_q;
    jy_d   = load ? jy_n   : jy_q;
    smpx_d = load ? smpx_n : smpx_q;
    smpy_d = load ? smpy_n : smpy_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      halt13_q <= 1'b1;
      vld_q    <= 1'b0;
      sx_q     <= '0;
      sy_q     <= '0;
      llx_q    <= '0;
      urx_q    <= '0;
      ury_q    <= '0;
      step_q   <= '0;
      tri_q    <= '{default: '{default: '0}};
      col_q    <= '{default: '0};
      smpx_q   <= '0;
      smpy_q   <= '0;
      jx_q     <= '0;
      jy_q     <= '0;
    end else begin
      state_q  <= state_d;
      halt13_q <= halt13_d;
      vld_q    <= vld_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      llx_q    <= llx_d;
      urx_q    <= urx_d;
      ury_q    <= ury_d;
      step_q   <= step_d;
      tri_q    <= tri_d;
      col_q    <= col_d;
      smpx_q   <= smpx_d;
      smpy_q   <= smpy_d;
      jx_q     <= jx_d;
      jy_q     <= jy_d;
    end
  end

  assign halt_R13L      = halt13_q;
  assign validSamp_R14H = vld_q;
  assign s_x_R14S       = sx_q;
  assign s_y_R14S       = sy_q;
  assign tri_R14S       = tri_q;
  assign color_R14U     = col_q;
  assign sample_R14S[0] = smpx_q;
  assign sample_R14S[1] = smpy_q;
  assign jitter_x_R14S  = jx_q;
  assign jitter_y_R14S  = jy_q;

endmodule

// File: tb/tb_smpl_sweep.sv
// Bench for smpl_sweep: directed boxes, stalls, reset mid-sweep and randomized boxes against a grid-list model.
module tb_smpl_sweep;
  localparam int SF = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic signed [SF-1:0] tri_i   [2:0][2:0];
  logic        [SF-1:0] color_i [2:0];
  logic signed [SF-1:0] box_i   [1:0][1:0];
  logic                 validTri;
  logic                 halt13;
  logic        [3:0]    sub;
  logic                 haltN;
  logic signed [SF-1:0] tri_o   [2:0][2:0];
  logic        [SF-1:0] color_o [2:0];
  logic signed [SF-1:0] samp_o  [1:0];
  logic                 vld;
  logic signed [SF-1:0] sx, sy;
  logic        [7:0]    jx, jy;

  smpl_sweep dut (
    .clk(clk), .rst(rst),
    .tri_R13S(tri_i), .color_R13U(color_i), .box_R13S(box_i),
    .validTri_R13H(validTri), .halt_R13L(halt13),
    .subSample_RnnnnU(sub), .halt_RnnnnL(haltN),
    .tri_R14S(tri_o), .color_R14U(color_o), .sample_R14S(samp_o),
    .validSamp_R14H(vld), .s_x_R14S(sx), .s_y_R14S(sy),
    .jitter_x_R14S(jx), .jitter_y_R14S(jy)
  );

  int errors = 0;
  int checks = 0;
  int ex_x[$];
  int ex_y[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int step_of(input logic [3:0] s);
    case (s)
      4'b0001: return 128;
      4'b0010: return 256;
      4'b0100: return 512;
      default: return 1024;
    endcase
  endfunction

  // Expected sample position and jitter for a grid point.
  function automatic void exp_samp(input int x, input int y, input int step,
                                   output int smx, output int smy, output int ejx, output int ejy);
`ifdef SAMPLE_JITTER_EN
    int ix, iy;
    ix  = (x / 1024) % 16;
    iy  = (y / 1024) % 16;
    ejx = (ix * 16 + iy) ^ 8'hA5;
    ejy = (iy * 16 + ix) ^ 8'h5A;
    smx = x + (ejx * step) / 256;
    smy = y + (ejy * step) / 256;
`else
    ejx = 0;
    ejy = 0;
    smx = x;
    smy = y;
`endif
  endfunction

  task automatic run_tri(input int llx, input int lly, input int urx, input int ury,
                         input logic [3:0] s, input int stall_pct,
                         input int stall_after, input int stall_len);
    int step, n, idx, cyc, low, stalls, stall_left;
    int smx, smy, ejx, ejy;
    bit stall_done;
    logic signed [SF-1:0] t_exp [2:0][2:0];
    logic        [SF-1:0] c_exp [2:0];
    step = step_of(s);
    ex_x.delete();
    ex_y.delete();
    for (int y = lly; y <= ury; y += step)
      for (int x = llx; x <= urx; x += step) begin
        ex_x.push_back(x);
        ex_y.push_back(y);
      end
    n = ex_x.size();

    @(negedge clk);
    chk("idle_halt", halt13, 1);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) tri_i[i][j] = SF'($urandom);
      color_i[i] = SF'($urandom);
    end
    t_exp = tri_i;
    c_exp = color_i;
    box_i[0][0] = SF'(llx); box_i[0][1] = SF'(lly);
    box_i[1][0] = SF'(urx); box_i[1][1] = SF'(ury);
    sub      = s;
    validTri = 1'b1;
    haltN    = 1'($urandom_range(0, 1));

    @(negedge clk);
    sub      = 4'b0001 << $urandom_range(0, 3);
    validTri = (n == 0) ? 1'b0 : 1'($urandom_range(0, 1));
    if (n == 0) begin
      chk("drop_vld", vld, 0);
      chk("drop_halt", halt13, 1);
      @(negedge clk);
      chk("drop_vld2", vld, 0);
      chk("drop_halt2", halt13, 1);
      return;
    end
    idx = 0; cyc = 0; low = 0; stalls = 0; stall_left = 0; stall_done = 0;
    while (idx < n && cyc < 400) begin
      exp_samp(ex_x[idx], ex_y[idx], step, smx, smy, ejx, ejy);
      chk("vld", vld, 1);
      chk("sweep_halt", halt13, 0);
      chk("s_x", sx, ex_x[idx]);
      chk("s_y", sy, ex_y[idx]);
      chk("sample_x", samp_o[0], smx);
      chk("sample_y", samp_o[1], smy);
      chk("jitter_x", jx, ejx);
      chk("jitter_y", jy, ejy);
      chk("tri", tri_o[idx % 3][(idx + 1) % 3], t_exp[idx % 3][(idx + 1) % 3]);
      chk("color", color_o[idx % 3], c_exp[idx % 3]);
      low++;
      if (stall_left > 0) begin
        haltN = 1'b0;
        stall_left--;
      end else if (idx == stall_after && !stall_done) begin
        haltN      = 1'b0;
        stall_left = stall_len - 1;
        stall_done = 1;
      end else begin
        haltN = ($urandom_range(0, 99) >= stall_pct);
      end
      if (haltN) idx++;
      else stalls++;
      if (idx == n) validTri = 1'b0;
      else validTri = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
    end
    if (idx < n) chk("sweep_timeout", idx, n);
    chk("end_vld", vld, 0);
    chk("end_halt", halt13, 1);
    chk("halt_low_cycles", low, n + stalls);
    haltN = 1'b1;
  endtask

  initial begin
    rst      = 1'b0;
    validTri = 1'b0;
    haltN    = 1'b1;
    sub      = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) tri_i[i][j] = '0;
      color_i[i] = '0;
    end
    box_i[0][0] = '0; box_i[0][1] = '0; box_i[1][0] = '0; box_i[1][1] = '0;
    repeat (2) @(negedge clk);
    chk("rst_vld", vld, 0);
    chk("rst_halt", halt13, 1);
    chk("rst_sx", sx, 0);
    chk("rst_sy", sy, 0);
    chk("rst_sample", samp_o[0], 0);
    chk("rst_jitter", jx, 0);
    chk("rst_tri", tri_o[0][0], 0);
    chk("rst_color", color_o[2], 0);
    rst = 1'b1;

    run_tri(0, 0, 2048, 1024, 4'b1000, 0, -1, 0);
    run_tri(0, 0, 2048, 1024, 4'b1000, 0, 2, 3);
    run_tri(512, 512, 512, 512, 4'b0001, 0, -1, 0);
    run_tri(1024, 0, 0, 0, 4'b1000, 0, -1, 0);

    // Reset while the third sample is presented.
    @(negedge clk);
    box_i[0][0] = 0; box_i[0][1] = 0; box_i[1][0] = 2048; box_i[1][1] = 1024;
    sub = 4'b1000;
    validTri = 1'b1;
    haltN = 1'b1;
    @(negedge clk);
    validTri = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_sx", sx, 2048);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_vld", vld, 0);
    chk("mid_rst_halt", halt13, 1);
    chk("mid_rst_sx", sx, 0);
    rst = 1'b1;
    run_tri(0, 0, 0, 0, 4'b1000, 0, -1, 0);

`ifdef SAMPLE_JITTER_EN
    @(negedge clk);
    box_i[0][0] = 1024; box_i[0][1] = 2048; box_i[1][0] = 1024; box_i[1][1] = 2048;
    sub = 4'b1000;
    validTri = 1'b1;
    @(negedge clk);
    validTri = 1'b0;
    chk("jit_x_const", jx, 8'hB7);
    chk("jit_y_const", jy, 8'h7B);
    chk("jit_sx_const", samp_o[0], 1756);
    chk("jit_sy_const", samp_o[1], 2540);
    @(negedge clk);
`endif

    for (int k = 0; k < 12; k++) begin
      logic [3:0] s;
      int st, llx, lly, urx, ury;
      s   = 4'b0001 << $urandom_range(0, 3);
      st  = step_of(s);
      llx = $urandom_range(0, 8) * st;
      lly = $urandom_range(0, 8) * st;
      urx = llx + $urandom_range(0, 3) * st;
      ury = lly + $urandom_range(0, 2) * st;
      if (k % 5 == 4 && lly >= st) ury = lly - st;
      run_tri(llx, lly, urx, ury, s, 30, -1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
